int_divider: RTL and testbench

INT_DIVIDER -- requirements
Module: int_divider

---
 rtl/int_divider.sv | 150 +++++++++++++++
 tb/tb_int_divider.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_divider.sv
// Multi-cycle RV32M integer divider (DIV/DIVU/REM/REMU) built on a restoring shift-subtract loop.
// Optional macro DIVIDER_ZERO_BYPASS_EN skips the iteration loop when the divisor is zero.
module int_divider #(
    parameter int N_DATA     = 32,
    parameter int N_REG_ADDR = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [N_DATA-1:0]     dividend,
    input  logic [N_DATA-1:0]     divisor,
    input  logic [N_REG_ADDR-1:0] rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic [N_DATA-1:0]     result,
    output logic [N_REG_ADDR-1:0] rd_out,
    output logic                  write_enable
);

    localparam int CNT_W = $clog2(N_DATA + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_DATA - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ITERATE, FIXUP, DONE} state_t;

    state_t                  state_q;
    logic [1:0]              op_q;
    logic [N_DATA-1:0]       a_q, b_q;
    logic [N_REG_ADDR-1:0]   rd_q;
    logic [N_DATA-1:0]       quo_q, rem_q, dvs_q;
    logic                    neg_quo_q, neg_rem_q, zero_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [N_DATA-1:0]       result_q;
    logic [N_REG_ADDR-1:0]   rd_out_q;
    logic                    done_q, we_q;

    logic [N_DATA:0]         shift_d;
    logic                    ge_d;
    logic [N_DATA-1:0]       diff_d;
    logic [N_DATA-1:0]       fix_d;
    logic                    signed_op;
    logic                    bypass_d;

    function automatic logic [N_DATA-1:0] magnitude(input logic signed [N_DATA-1:0] x,
                                                    input logic sgn);
        return (sgn && x[N_DATA-1]) ? -x : x;
    endfunction

    function automatic logic [N_DATA-1:0] apply_sign(input logic signed [N_DATA-1:0] x,
                                                     input logic neg);
        return neg ? -x : x;
    endfunction

    assign signed_op = ~op_q[0];

`ifdef DIVIDER_ZERO_BYPASS_EN
    assign bypass_d = (b_q == '0);
`else
    assign bypass_d = 1'b0;
`endif

    // Restoring step: shift_d is the (N_DATA+1)-bit partial remainder; the low N_DATA bits of the
    // difference are exact whenever the subtraction is kept, since the result is below the divisor.
    always_comb begin
        shift_d = {rem_q, quo_q[N_DATA-1]};
        ge_d    = (shift_d >= {1'b0, dvs_q});
        diff_d  = shift_d[N_DATA-1:0] - dvs_q;
    end

    // Zero divisor overrides the loop output so signed ops do not get sign-corrected.
    always_comb begin
        fix_d = op_q[1] ? apply_sign(rem_q, neg_rem_q) : apply_sign(quo_q, neg_quo_q);
        if (zero_q) begin
            fix_d = op_q[1] ? a_q : '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= dividend;
                        b_q     <= divisor;
                        rd_q    <= rd_addr;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    quo_q     <= magnitude(a_q, signed_op);
                    dvs_q     <= magnitude(b_q, signed_op);
                    rem_q     <= '0;
                    cnt_q     <= '0;
                    neg_quo_q <= signed_op & (a_q[N_DATA-1] ^ b_q[N_DATA-1]);
                    neg_rem_q <= signed_op & a_q[N_DATA-1];
                    zero_q    <= (b_q == '0);
                    state_q   <= bypass_d ? FIXUP : ITERATE;
                end
                ITERATE: begin
                    rem_q <= ge_d ? diff_d : shift_d[N_DATA-1:0];
                    quo_q <= {quo_q[N_DATA-2:0], ge_d};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    result_q <= fix_d;
                    rd_out_q <= rd_q;
                    done_q   <= 1'b1;
                    we_q     <= (rd_q != '0);
                    state_q  <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign result       = result_q;
    assign rd_out       = rd_out_q;
    assign write_enable = we_q;

endmodule

// File: tb/tb_int_divider.sv
// Scoreboard bench for int_divider: stimulus pushes expected results, a negedge monitor checks them.
module tb_int_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        write_enable;

`ifdef DIVIDER_ZERO_BYPASS_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 34;
`endif
    localparam int LAT = 34;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic prev_done = 1'b0;

    int_divider #(.N_DATA(32), .N_REG_ADDR(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .dividend     (dividend),
        .divisor      (divisor),
        .rd_addr      (rd_addr),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .rd_out       (rd_out),
        .write_enable (write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Issue one request on the first idle cycle; track=0 means no response is expected.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] er, input int lat,
                         input bit track);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) fail_now("issue_wait_idle");
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        rd_addr  = rd;
        if (track) begin
            e.res = er;
            e.rd  = rd;
            e.we  = (rd != 5'd0);
            e.acc = cyc + 1;
            e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        rd_addr  = 5'($urandom);
        op       = 2'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: result 0x%08h rd_out %0d with no request pending",
                         result, rd_out);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("rd_out", 32'(rd_out), 32'(mon_e.rd));
                chk("write_enable", 32'(write_enable), 32'(mon_e.we));
                chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
            chk("done_one_cycle", 32'(prev_done), 32'd0);
        end
        prev_done <= done;
    end

    initial begin
        int w;
        int dn;
        rst      = 1'b0;
        start    = 1'b0;
        op       = 2'd0;
        dividend = '0;
        divisor  = '0;
        rd_addr  = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_we", 32'(write_enable), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(2'd1, 32'd100, 32'd7, 5'd5, 32'd14, LAT, 1'b1);
        issue(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, LAT, 1'b1);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, LAT, 1'b1);
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'd1, LAT, 1'b1);
        issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, LAT, 1'b1);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0, LAT, 1'b1);
        issue(2'd0, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'hFFFF_FFF2, LAT, 1'b1);
        issue(2'd2, 32'd100, 32'hFFFF_FFF9, 5'd9, 32'd2, LAT, 1'b1);
        issue(2'd1, 32'd123, 32'd0, 5'd10, 32'hFFFF_FFFF, ZLAT, 1'b1);
        issue(2'd3, 32'd123, 32'd0, 5'd11, 32'd123, ZLAT, 1'b1);
        issue(2'd0, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFFF, ZLAT, 1'b1);
        issue(2'd2, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFF9, ZLAT, 1'b1);

        // A start while busy, and another during the DONE cycle, must both be dropped.
        issue(2'd1, 32'd20, 32'd4, 5'd3, 32'd5, LAT, 1'b1);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        op       = 2'd1;
        dividend = 32'd9;
        divisor  = 32'd3;
        rd_addr  = 5'd7;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!done && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!done) fail_now("wait_done_for_done_cycle_start");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        issue(2'd1, 32'd9, 32'd3, 5'd0, 32'd3, LAT, 1'b1);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) fail_now("drain_before_abort");

        // Abort a division mid-flight with an asynchronous reset pulse.
        issue(2'd1, 32'd1000, 32'd10, 5'd2, 32'd0, LAT, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_we", 32'(write_enable), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no_done_after_abort", 32'(dn), 32'd0);

        issue(2'd1, 32'd8, 32'd2, 5'd4, 32'd4, LAT, 1'b1);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) fail_now("drain_at_end");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
